dsp_mul_nch: RTL and testbench



---
 rtl/dsp_mul_nch.sv | 150 +++++++++++++++
 tb/tb_dsp_mul_nch.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dsp_mul_nch.sv
// CH-channel signed multiplier: one shared sample times CH coefficients, scaled by DROP bits,
// rounded by a run-time mode, then saturated or wrapped to O_W bits over a two-stage pipeline.
module dsp_mul_nch #(
    parameter int I_W  = 12,
    parameter int O_W  = 16,
    parameter int CH   = 2,
    parameter int DROP = 2*I_W - O_W,
    parameter int SAT  = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic signed [I_W-1:0]   din,
    input  logic [CH*I_W-1:0]       cin,
    input  logic [1:0]              rnd_mode,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic [CH*O_W-1:0]       dout,
    output logic [CH-1:0]           out_ovf,
    output logic                    out_valid,
    input  logic                    out_ready,
    input  logic                    ovf_clr,
    output logic [CH-1:0]           ovf_sticky
);

    localparam int PW = 2*I_W;
    // Working width leaves headroom above both the product and the output range for compares.
    localparam int WW = ((PW > O_W) ? PW : O_W) + 2;
    localparam logic [PW-1:0] LMASK = (PW'(1) << (DROP-1)) - PW'(1);
    localparam logic signed [WW-1:0] MAX_V = {{(WW-O_W+1){1'b0}}, {(O_W-1){1'b1}}};
    localparam logic signed [WW-1:0] MIN_V = {{(WW-O_W+1){1'b1}}, {(O_W-1){1'b0}}};

    typedef enum logic [1:0] {
        RND_TRUNC = 2'd0,
        RND_AWAY  = 2'd1,
        RND_EVEN  = 2'd2,
        RND_UP    = 2'd3
    } rnd_e;

    logic                   en;
    logic                   v1_q, v1_d;
    rnd_e                   mode1_q, mode1_d;
    logic signed [PW-1:0]   p_q [CH];
    logic signed [PW-1:0]   p_d [CH];
    logic                   out_valid_q, out_valid_d;
    logic [CH*O_W-1:0]      dout_q, dout_d;
    logic [CH-1:0]          ovf_q, ovf_d;
    logic [CH-1:0]          sticky_q, sticky_d;

    assign en = !out_valid_q || out_ready;

    // Stage 1: capture the beat and form full-width products.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        v1_d    = v1_q;
        mode1_d = mode1_q;
        for (int k = 0; k < CH; k++) begin
            p_d[k] = p_q[k];
        end
        if (en) begin
            v1_d    = in_valid;
            mode1_d = rnd_e'(rnd_mode);
            for (int k = 0; k < CH; k++) begin
                p_d[k] = PW'(din) * PW'($signed(cin[k*I_W +: I_W]));
            end
        end
    end

    // Stage 2: round, range-check and clamp or wrap each channel.
    always_comb begin
        logic signed [WW-1:0] pe;
        logic signed [WW-1:0] q;
        logic signed [WW-1:0] r;
        logic                 h;
        logic                 l;
        logic                 inc;
        logic                 of;
        out_valid_d = out_valid_q;
        dout_d      = dout_q;
        ovf_d       = ovf_q;
        pe  = '0;
        q   = '0;
        r   = '0;
        h   = 1'b0;
        l   = 1'b0;
        inc = 1'b0;
        of  = 1'b0;
        if (en) begin
            out_valid_d = v1_q;
            for (int k = 0; k < CH; k++) begin
                pe = {{(WW-PW){p_q[k][PW-1]}}, p_q[k]};
                q  = pe >>> DROP;
                h  = p_q[k][DROP-1];
                l  = |(p_q[k] & LMASK);
                unique case (mode1_q)
                    RND_TRUNC: inc = 1'b0;
                    RND_AWAY:  inc = p_q[k][PW-1] ? (h & l) : h;
                    RND_EVEN:  inc = h & (l | q[0]);
                    RND_UP:    inc = h;
                    default:   inc = 1'b0;
                endcase
                r  = q + {{(WW-1){1'b0}}, inc};
                of = (r > MAX_V) || (r < MIN_V);
                if (of && (SAT != 0)) begin
                    dout_d[k*O_W +: O_W] = (r > MAX_V) ? MAX_V[O_W-1:0] : MIN_V[O_W-1:0];
                end else begin
                    dout_d[k*O_W +: O_W] = r[O_W-1:0];
                end
                ovf_d[k] = of & v1_q;
            end
        end
    end

    // A clear loses to a flag being set by the beat accepted in the same cycle.
    always_comb begin
        sticky_d = (ovf_clr ? '0 : sticky_q) | ((out_valid_q && out_ready) ? ovf_q : '0);
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    // NOTE: the data registers are reset too, so dout reads zero and no in-flight product survives a reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1_q        <= 1'b0;
            mode1_q     <= RND_TRUNC;
            out_valid_q <= 1'b0;
            dout_q      <= '0;
            ovf_q       <= '0;
            sticky_q    <= '0;
            for (int k = 0; k < CH; k++) begin
                p_q[k] <= '0;
            end
        end else begin
            v1_q        <= v1_d;
            mode1_q     <= mode1_d;
            out_valid_q <= out_valid_d;
            dout_q      <= dout_d;
            ovf_q       <= ovf_d;
            sticky_q    <= sticky_d;
            for (int k = 0; k < CH; k++) begin
                p_q[k] <= p_d[k];
            end
        end
    end

    assign in_ready   = en;
    assign dout       = dout_q;
    assign out_ovf    = ovf_q;
    assign out_valid  = out_valid_q;
    assign ovf_sticky = sticky_q;

endmodule

// File: tb/tb_dsp_mul_nch.sv
// Directed bench for dsp_mul_nch: default build plus DROP=4 saturating and wrapping builds
// driven from the same stimulus.
module tb_dsp_mul_nch;

    logic        clk;
    logic        rst_n;
    logic [11:0] din;
    logic [23:0] cin;
    logic [1:0]  rnd_mode;
    logic        in_valid;
    logic        out_ready;
    logic        ovf_clr;

    logic        in_ready_a, valid_a, in_ready_b, valid_b, in_ready_c, valid_c;
    logic [31:0] dout_a, dout_b, dout_c;
    logic [1:0]  ovf_a, ovf_b, ovf_c, sticky_a, sticky_b, sticky_c;

    int n_vec;
    int n_err;

    typedef struct {
        int din;
        int c0;
        int c1;
        int mode;
        int e0;
        int e1;
    } vec_t;

    vec_t vecs [22];

    dsp_mul_nch u_dut (
        .clk(clk), .rst_n(rst_n), .din(din), .cin(cin), .rnd_mode(rnd_mode),
        .in_valid(in_valid), .in_ready(in_ready_a), .dout(dout_a), .out_ovf(ovf_a),
        .out_valid(valid_a), .out_ready(out_ready), .ovf_clr(ovf_clr), .ovf_sticky(sticky_a)
    );

    dsp_mul_nch #(.DROP(4), .SAT(1)) u_d4s (
        .clk(clk), .rst_n(rst_n), .din(din), .cin(cin), .rnd_mode(rnd_mode),
        .in_valid(in_valid), .in_ready(in_ready_b), .dout(dout_b), .out_ovf(ovf_b),
        .out_valid(valid_b), .out_ready(out_ready), .ovf_clr(ovf_clr), .ovf_sticky(sticky_b)
    );

    dsp_mul_nch #(.DROP(4), .SAT(0)) u_d4w (
        .clk(clk), .rst_n(rst_n), .din(din), .cin(cin), .rnd_mode(rnd_mode),
        .in_valid(in_valid), .in_ready(in_ready_c), .dout(dout_c), .out_ovf(ovf_c),
        .out_valid(valid_c), .out_ready(out_ready), .ovf_clr(ovf_clr), .ovf_sticky(sticky_c)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input longint act, input longint exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic longint chv(input logic [31:0] d, input int k);
        logic signed [15:0] t;
        t = d[k*16 +: 16];
        return longint'(t);
    endfunction

    // Reference rounding written from the remainder, independent of bit-level tricks.
    function automatic longint ref_val(input longint p, input int m, input int drop);
        longint q, rem, half, r;
        q    = p >>> drop;
        rem  = p - (q <<< drop);
        half = longint'(1) <<< (drop - 1);
        case (m)
            0:       r = q;
            1:       r = q + longint'((rem > half) || (rem == half && p >= 0));
            2:       r = q + longint'((rem > half) || (rem == half && q[0]));
            default: r = q + longint'(rem >= half);
        endcase
        if (r > 32767) r = 32767;
        if (r < -32768) r = -32768;
        return r;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Apply one beat and return with its result visible on the outputs.
    task automatic beat(input int d, input int c0, input int c1, input int m);
        din       = d[11:0];
        cin       = {c1[11:0], c0[11:0]};
        rnd_mode  = m[1:0];
        in_valid  = 1'b1;
        out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        for (int i = 0; i < 8 && !valid_a; i++) step();
        if (!valid_a) check("beat_timeout", 0, 1);
    endtask

    longint exp_q0 [$];
    longint exp_q1 [$];
    int     pat [6];
    int     sent, got, cyc, sd, sc0, sc1, sm;
    bit     hold_chk;
    logic [31:0] held;

    initial begin
        n_vec = 0;
        n_err = 0;
        vecs[0]  = '{3, 128, -128, 0, 1, -2};
        vecs[1]  = '{3, 128, -128, 1, 2, -2};
        vecs[2]  = '{3, 128, -128, 2, 2, -2};
        vecs[3]  = '{3, 128, -128, 3, 2, -1};
        vecs[4]  = '{5, 128, 0, 0, 2, 0};
        vecs[5]  = '{5, 128, 0, 1, 3, 0};
        vecs[6]  = '{5, 128, 0, 2, 2, 0};
        vecs[7]  = '{5, 128, 0, 3, 3, 0};
        vecs[8]  = '{-2048, -2048, 2047, 0, 16384, -16376};
        vecs[9]  = '{-2048, -2048, 2047, 2, 16384, -16376};
        vecs[10] = '{2047, 2047, -2048, 0, 16368, -16376};
        vecs[11] = '{2047, 2047, -2048, 1, 16368, -16376};
        vecs[12] = '{2047, 2047, -2048, 2, 16368, -16376};
        vecs[13] = '{2047, 2047, -2048, 3, 16368, -16376};
        vecs[14] = '{-1, 1, -1, 0, -1, 0};
        vecs[15] = '{-1, 1, -1, 1, 0, 0};
        vecs[16] = '{-1, 1, -1, 2, 0, 0};
        vecs[17] = '{-1, 1, -1, 3, 0, 0};
        vecs[18] = '{-5, 128, 192, 0, -3, -4};
        vecs[19] = '{-5, 128, 192, 1, -3, -4};
        vecs[20] = '{-5, 128, 192, 2, -2, -4};
        vecs[21] = '{-5, 128, 192, 3, -2, -4};
        pat = '{1, 0, 0, 1, 0, 1};

        rst_n = 1'b0; din = '0; cin = '0; rnd_mode = '0;
        in_valid = 1'b0; out_ready = 1'b1; ovf_clr = 1'b0;
        step();
        check("rst_valid", valid_a, 0);
        check("rst_dout", dout_a, 0);
        check("rst_ovf", ovf_a, 0);
        check("rst_sticky", sticky_a, 0);
        rst_n = 1'b1;
        step();

        // Rounding table on the default build.
        for (int i = 0; i < 22; i++) begin
            beat(vecs[i].din, vecs[i].c0, vecs[i].c1, vecs[i].mode);
            check($sformatf("vec%0d_ch0", i), chv(dout_a, 0), vecs[i].e0);
            check($sformatf("vec%0d_ch1", i), chv(dout_a, 1), vecs[i].e1);
            check($sformatf("vec%0d_ovf", i), ovf_a, 0);
        end
        step();

        // DROP=4 in range, then overflow on both channels.
        beat(3, 128, -128, 0);
        check("d4_small_ch0", chv(dout_b, 0), 24);
        check("d4_small_ch1", chv(dout_b, 1), -24);
        check("d4_small_ovf", ovf_b, 0);
        beat(2047, 2047, -2048, 0);
        check("d4s_ch0", chv(dout_b, 0), 32767);
        check("d4s_ch1", chv(dout_b, 1), -32768);
        check("d4s_ovf", ovf_b, 3);
        check("d4w_ch0", chv(dout_c, 0), -256);
        check("d4w_ch1", chv(dout_c, 1), 128);
        check("d4w_ovf", ovf_c, 3);
        step();
        check("sticky_set_s", sticky_b, 3);
        check("sticky_set_w", sticky_c, 3);
        check("sticky_default", sticky_a, 0);
        step(); step(); step();
        check("sticky_hold", sticky_b, 3);
        ovf_clr = 1'b1;
        step();
        ovf_clr = 1'b0;
        check("sticky_clr_s", sticky_b, 0);
        check("sticky_clr_w", sticky_c, 0);
        beat(2047, 2047, -2048, 3);
        ovf_clr = 1'b1;
        step();
        ovf_clr = 1'b0;
        check("sticky_set_wins", sticky_b, 3);
        step(); step();

        // Streaming with a stalling consumer against the reference model.
        sent = 0; got = 0; cyc = 0; hold_chk = 1'b0; held = '0;
        while (got < 20 && cyc < 400) begin
            out_ready = pat[cyc % 6][0];
            if (sent < 20) begin
                sd  = ((sent * 397 + 11) % 4096) - 2048;
                sc0 = ((sent * 733 + 5) % 4096) - 2048;
                sc1 = ((sent * 1291 + 77) % 4096) - 2048;
                sm  = sent % 4;
                din = sd[11:0]; cin = {sc1[11:0], sc0[11:0]}; rnd_mode = sm[1:0];
                in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clk);
            check("in_ready_en", in_ready_a, !valid_a || out_ready);
            if (hold_chk) begin
                check("stall_valid", valid_a, 1);
                check("stall_dout", dout_a, held);
            end
            hold_chk = valid_a && !out_ready;
            held     = dout_a;
            if (valid_a && out_ready) begin
                if (exp_q0.size() == 0) begin
                    check("extra_beat", 1, 0);
                end else begin
                    check($sformatf("stream%0d_ch0", got), chv(dout_a, 0), exp_q0.pop_front());
                    check($sformatf("stream%0d_ch1", got), chv(dout_a, 1), exp_q1.pop_front());
                    check($sformatf("stream%0d_ovf", got), ovf_a, 0);
                end
                got++;
            end
            if (in_valid && in_ready_a) begin
                exp_q0.push_back(ref_val(longint'(sd) * longint'(sc0), sm, 8));
                exp_q1.push_back(ref_val(longint'(sd) * longint'(sc1), sm, 8));
                sent++;
            end
            step();
            cyc++;
        end
        if (got < 20) check("stream_timeout", got, 20);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            check("stream_no_dup", valid_a, 0);
            step();
        end
        check("stream_queue_empty", exp_q0.size(), 0);

        // Reset with two beats in flight.
        din = 12'd2047; cin = {12'h800, 12'd2047}; rnd_mode = 2'd0; in_valid = 1'b1;
        step();
        step();
        in_valid = 1'b0;
        check("pre_rst_valid", valid_b, 1);
        rst_n = 1'b0;
        #1;
        check("midrst_valid", valid_b, 0);
        check("midrst_dout", dout_b, 0);
        check("midrst_ovf", ovf_b, 0);
        check("midrst_sticky", sticky_b, 0);
        step();
        rst_n = 1'b1;
        step();
        din = 12'd3; cin = {12'hF80, 12'd128}; rnd_mode = 2'd1; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        check("post_rst_lat1", valid_a, 0);
        step();
        check("post_rst_lat2", valid_a, 1);
        check("post_rst_ch0", chv(dout_a, 0), 2);
        check("post_rst_ch1", chv(dout_a, 1), -2);
        step();
        check("post_rst_drain", valid_a, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
